// File: rtl/tl_edge_queue_if.sv
// TileLink-UL edge bundle: A channel flows master->slave, D channel flows slave->master.
interface tl_edge_queue_if #(
    parameter int SOURCE_W = 7,
    parameter int ADDR_W   = 36,
    parameter int DATA_W   = 256
);
    localparam int MASK_W = DATA_W / 8;

    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [ADDR_W-1:0]   a_address;
    logic [MASK_W-1:0]   a_mask;
    logic [DATA_W-1:0]   a_data;

    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [2:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_denied;
    logic [DATA_W-1:0]   d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data,
        input  d_ready
    );
endinterface

// File: rtl/tl_edge_queue.sv
// TileLink-UL edge buffer: independent A (in->out) and D (out->in) circular queues with
// configurable depth, flow (bypass when empty) and pipe (ready-through when full) modes.
module tl_edge_queue_chan #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int PIPE  = 1,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_bits,
    output logic [CNT_W-1:0] count
);
    if (DEPTH == 0) begin : g_wire
        localparam int unused_mode = FLOW + PIPE;
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;
        assign out_valid      = in_valid;
        assign in_ready       = out_ready;
        assign out_bits       = in_bits;
        assign count          = '0;
    end else begin : g_queue
        localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
        localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

        logic [W-1:0]     mem_q [DEPTH];
        logic [PTR_W-1:0] enq_q, enq_d;
        logic [PTR_W-1:0] deq_q, deq_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic             empty, full, enq, deq, wr, rd;

        assign empty     = (count_q == '0);
        assign full      = (count_q == FULL_CNT);
        assign in_ready  = !full || ((PIPE != 0) && out_ready);
        assign out_valid = !empty || ((FLOW != 0) && in_valid);
        assign out_bits  = empty ? in_bits : mem_q[deq_q];
        assign count     = count_q;

        assign enq = in_valid && in_ready;
        assign deq = out_valid && out_ready;
        // A beat dequeued while empty can only be a flow bypass: it never touches storage.
        assign rd  = deq && !empty;
        assign wr  = enq && !(deq && empty);

        always_comb begin
            enq_d   = enq_q;
            deq_d   = deq_q;
            count_d = count_q + CNT_W'(wr) - CNT_W'(rd);
            if (wr) enq_d = (enq_q == LAST_PTR) ? '0 : enq_q + 1'b1;
            if (rd) deq_d = (deq_q == LAST_PTR) ? '0 : deq_q + 1'b1;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                enq_q   <= '0;
                deq_q   <= '0;
                count_q <= '0;
            end else begin
                enq_q   <= enq_d;
                deq_q   <= deq_d;
                count_q <= count_d;
            end
        end

        // Storage is deliberately not reset; stale entries are unreachable once count is 0.
        always_ff @(posedge clock) begin
            if (wr) mem_q[enq_q] <= in_bits;
        end

        a_count_bound: assert property (@(posedge clock) disable iff (reset) count_q <= FULL_CNT);
        a_no_overflow: assert property (@(posedge clock) disable iff (reset) wr |-> (!full || rd));
    end
endmodule

module tl_edge_queue #(
    parameter int SOURCE_W = 7,
    parameter int ADDR_W   = 36,
    parameter int DATA_W   = 256,
    parameter int A_DEPTH  = 2,
    parameter int D_DEPTH  = 2,
    parameter int A_FLOW   = 0,
    parameter int D_FLOW   = 0,
    parameter int A_PIPE   = 1,
    parameter int D_PIPE   = 1,
    localparam int A_CNT_W = (A_DEPTH > 0) ? $clog2(A_DEPTH + 1) : 1,
    localparam int D_CNT_W = (D_DEPTH > 0) ? $clog2(D_DEPTH + 1) : 1
) (
    input  logic               clock,
    input  logic               reset,
    tl_edge_queue_if.slave     io_in,
    tl_edge_queue_if.master    io_out,
    output logic [A_CNT_W-1:0] a_count,
    output logic [D_CNT_W-1:0] d_count
);
    localparam int MASK_W = DATA_W / 8;
    localparam int A_W    = 3 + 3 + SOURCE_W + ADDR_W + MASK_W + DATA_W;
    localparam int D_W    = 3 + 2 + 3 + SOURCE_W + 1 + DATA_W;

    logic [A_W-1:0] a_in_bits, a_out_bits;
    logic [D_W-1:0] d_in_bits, d_out_bits;

    assign a_in_bits = {io_in.a_opcode, io_in.a_size, io_in.a_source,
                        io_in.a_address, io_in.a_mask, io_in.a_data};
    assign {io_out.a_opcode, io_out.a_size, io_out.a_source,
            io_out.a_address, io_out.a_mask, io_out.a_data} = a_out_bits;

    // D travels from the downstream side (io_out) back to the upstream side (io_in).
    assign d_in_bits = {io_out.d_opcode, io_out.d_param, io_out.d_size,
                        io_out.d_source, io_out.d_denied, io_out.d_data};
    assign {io_in.d_opcode, io_in.d_param, io_in.d_size,
            io_in.d_source, io_in.d_denied, io_in.d_data} = d_out_bits;

    tl_edge_queue_chan #(
        .W(A_W), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE), .CNT_W(A_CNT_W)
    ) u_a_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (io_in.a_valid),
        .in_ready  (io_in.a_ready),
        .in_bits   (a_in_bits),
        .out_valid (io_out.a_valid),
        .out_ready (io_out.a_ready),
        .out_bits  (a_out_bits),
        .count     (a_count)
    );

    tl_edge_queue_chan #(
        .W(D_W), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE), .CNT_W(D_CNT_W)
    ) u_d_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (io_out.d_valid),
        .in_ready  (io_out.d_ready),
        .in_bits   (d_in_bits),
        .out_valid (io_in.d_valid),
        .out_ready (io_in.d_ready),
        .out_bits  (d_out_bits),
        .count     (d_count)
    );
endmodule

// File: tb/tb_tl_edge_queue.sv
// Bench for tl_edge_queue: three configurations driven together, each channel checked
// cycle by cycle against a list-based reference queue.
module tb_tl_edge_queue;
    localparam int PW = 384;
    localparam int AW = 3 + 3 + 7 + 36 + 32 + 256;
    localparam int DW = 3 + 2 + 3 + 7 + 1 + 256;
    // Channels: 0/1 = defaults A/D, 2/3 = flow+no-pipe A / depth-3 D, 4/5 = depth-0 A/D.
    localparam int DEP  [6] = '{2, 2, 2, 3, 0, 0};
    localparam int FLW  [6] = '{0, 0, 1, 0, 0, 0};
    localparam int PIP  [6] = '{1, 1, 0, 1, 1, 1};
    localparam int BW   [6] = '{AW, DW, AW, DW, AW, DW};
    localparam int SRCL [6] = '{324, 257, 324, 257, 324, 257};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          iv   [6];
    logic          ordy [6];
    logic [PW-1:0] ib   [6];
    logic          ov   [6];
    logic          ir   [6];
    logic [PW-1:0] ob   [6];
    int            cnt  [6];

    logic [PW-1:0] mq [6][4];
    int            mn [6];
    bit            fired_in [6];
    bit            fired_out[6];
    logic [PW-1:0] out_seen [6];
    bit            chk_en;
    int            n_chk, n_err;

    logic [1:0] a_cnt0, d_cnt0, a_cnt1, d_cnt1;
    logic [0:0] a_cnt2, d_cnt2;

    tl_edge_queue_if i0_in (), i0_out ();
    tl_edge_queue_if i1_in (), i1_out ();
    tl_edge_queue_if i2_in (), i2_out ();

    tl_edge_queue u0 (.clock(clk), .reset(reset), .io_in(i0_in), .io_out(i0_out),
                      .a_count(a_cnt0), .d_count(d_cnt0));
    tl_edge_queue #(.A_FLOW(1), .A_PIPE(0), .D_DEPTH(3)) u1 (
        .clock(clk), .reset(reset), .io_in(i1_in), .io_out(i1_out),
        .a_count(a_cnt1), .d_count(d_cnt1));
    tl_edge_queue #(.A_DEPTH(0), .D_DEPTH(0)) u2 (
        .clock(clk), .reset(reset), .io_in(i2_in), .io_out(i2_out),
        .a_count(a_cnt2), .d_count(d_cnt2));

    assign i0_in.a_valid = iv[0];
    assign {i0_in.a_opcode, i0_in.a_size, i0_in.a_source, i0_in.a_address, i0_in.a_mask, i0_in.a_data} = ib[0][AW-1:0];
    assign i0_out.a_ready = ordy[0];
    assign ov[0] = i0_out.a_valid;
    assign ir[0] = i0_in.a_ready;
    assign ob[0] = PW'({i0_out.a_opcode, i0_out.a_size, i0_out.a_source, i0_out.a_address, i0_out.a_mask, i0_out.a_data});
    assign i0_out.d_valid = iv[1];
    assign {i0_out.d_opcode, i0_out.d_param, i0_out.d_size, i0_out.d_source, i0_out.d_denied, i0_out.d_data} = ib[1][DW-1:0];
    assign i0_in.d_ready = ordy[1];
    assign ov[1] = i0_in.d_valid;
    assign ir[1] = i0_out.d_ready;
    assign ob[1] = PW'({i0_in.d_opcode, i0_in.d_param, i0_in.d_size, i0_in.d_source, i0_in.d_denied, i0_in.d_data});
    assign cnt[0] = int'(a_cnt0);
    assign cnt[1] = int'(d_cnt0);

    assign i1_in.a_valid = iv[2];
    assign {i1_in.a_opcode, i1_in.a_size, i1_in.a_source, i1_in.a_address, i1_in.a_mask, i1_in.a_data} = ib[2][AW-1:0];
    assign i1_out.a_ready = ordy[2];
    assign ov[2] = i1_out.a_valid;
    assign ir[2] = i1_in.a_ready;
    assign ob[2] = PW'({i1_out.a_opcode, i1_out.a_size, i1_out.a_source, i1_out.a_address, i1_out.a_mask, i1_out.a_data});
    assign i1_out.d_valid = iv[3];
    assign {i1_out.d_opcode, i1_out.d_param, i1_out.d_size, i1_out.d_source, i1_out.d_denied, i1_out.d_data} = ib[3][DW-1:0];
    assign i1_in.d_ready = ordy[3];
    assign ov[3] = i1_in.d_valid;
    assign ir[3] = i1_out.d_ready;
    assign ob[3] = PW'({i1_in.d_opcode, i1_in.d_param, i1_in.d_size, i1_in.d_source, i1_in.d_denied, i1_in.d_data});
    assign cnt[2] = int'(a_cnt1);
    assign cnt[3] = int'(d_cnt1);

    assign i2_in.a_valid = iv[4];
    assign {i2_in.a_opcode, i2_in.a_size, i2_in.a_source, i2_in.a_address, i2_in.a_mask, i2_in.a_data} = ib[4][AW-1:0];
    assign i2_out.a_ready = ordy[4];
    assign ov[4] = i2_out.a_valid;
    assign ir[4] = i2_in.a_ready;
    assign ob[4] = PW'({i2_out.a_opcode, i2_out.a_size, i2_out.a_source, i2_out.a_address, i2_out.a_mask, i2_out.a_data});
    assign i2_out.d_valid = iv[5];
    assign {i2_out.d_opcode, i2_out.d_param, i2_out.d_size, i2_out.d_source, i2_out.d_denied, i2_out.d_data} = ib[5][DW-1:0];
    assign i2_in.d_ready = ordy[5];
    assign ov[5] = i2_in.d_valid;
    assign ir[5] = i2_out.d_ready;
    assign ob[5] = PW'({i2_in.d_opcode, i2_in.d_param, i2_in.d_size, i2_in.d_source, i2_in.d_denied, i2_in.d_data});
    assign cnt[4] = int'(a_cnt2);
    assign cnt[5] = int'(d_cnt2);

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_beat(input int c);
        logic [PW-1:0] b;
        for (int k = 0; k < PW / 32; k++) b[k*32 +: 32] = $urandom;
        return b & ((PW'(1) << BW[c]) - PW'(1));
    endfunction

    function automatic logic [PW-1:0] beat_src(input int c, input int s);
        logic [PW-1:0] b;
        b = rnd_beat(c);
        b[SRCL[c] +: 7] = 7'(s);
        return b;
    endfunction

    function automatic int src_of(input int c, input logic [PW-1:0] b);
        return int'(b[SRCL[c] +: 7]);
    endfunction

    task automatic idle();
        for (int k = 0; k < 6; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
        end
    endtask

    // One clock: compare every channel with the reference queue, then advance the reference.
    task automatic tick();
        #1;
        for (int c = 0; c < 6; c++) begin
            bit            ev, er;
            logic [PW-1:0] eb;
            if (DEP[c] == 0) begin
                ev = iv[c];
                er = ordy[c];
                eb = ib[c];
            end else begin
                ev = (mn[c] > 0) || (FLW[c] != 0 && iv[c]);
                er = (mn[c] < DEP[c]) || (PIP[c] != 0 && ordy[c]);
                eb = (mn[c] > 0) ? mq[c][0] : ib[c];
            end
            fired_in[c]  = iv[c] && ir[c];
            fired_out[c] = ov[c] && ordy[c];
            out_seen[c]  = ob[c];
            if (chk_en) begin
                check($sformatf("ch%0d out_valid", c), PW'(ov[c]), PW'(ev));
                check($sformatf("ch%0d in_ready", c), PW'(ir[c]), PW'(er));
                check($sformatf("ch%0d count", c), PW'(cnt[c]), PW'(mn[c]));
                if (ev) check($sformatf("ch%0d bits", c), ob[c], eb);
            end
            if (reset) begin
                mn[c] = 0;
            end else if (DEP[c] > 0) begin
                bit byp;
                byp = 1'b0;
                if (ev && ordy[c]) begin
                    if (mn[c] > 0) begin
                        for (int k = 0; k < 3; k++) mq[c][k] = mq[c][k+1];
                        mn[c]--;
                    end else begin
                        byp = 1'b1;
                    end
                end
                if (iv[c] && er && !byp) begin
                    mq[c][mn[c]] = ib[c];
                    mn[c]++;
                end
            end
        end
        @(negedge clk);
    endtask

    // Producer on channel c offers sources 0..n-1, retrying until accepted.
    task automatic burst(input int c, input int n, input int pct, input int hold);
        int s, got, last, maxc;
        s = 0; got = 0; last = -1; maxc = 0;
        for (int cyc = 0; cyc < n * 8 + hold + 10 && got < n; cyc++) begin
            idle();
            iv[c]   = (s < n);
            ib[c]   = beat_src(c, s);
            ordy[c] = (cyc >= hold) && ($urandom_range(99) < pct);
            tick();
            if (cnt[c] > maxc) maxc = cnt[c];
            if (fired_in[c]) s++;
            if (fired_out[c]) begin
                check($sformatf("burst ch%0d order", c), PW'(src_of(c, out_seen[c])), PW'(got));
                if (pct == 100 && last >= 0)
                    check($sformatf("burst ch%0d one per cycle", c), PW'(cyc - last), PW'(1));
                last = cyc;
                got++;
            end
            if (hold > 0 && cyc == hold - 1) begin
                check($sformatf("burst ch%0d held in_ready", c), PW'(ir[c]), PW'(0));
                check($sformatf("burst ch%0d held count", c), PW'(cnt[c]), PW'(2));
            end
        end
        check($sformatf("burst ch%0d delivered", c), PW'(got), PW'(n));
        check($sformatf("burst ch%0d max count", c), PW'(maxc <= DEP[c]), PW'(1));
    endtask

    initial begin
        logic [PW-1:0] nb;
        int            n_in, n_out;
        n_chk = 0; n_err = 0; chk_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mn[k] = 0;
            ib[k] = '0;
        end
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Back-pressure then release on the default A queue.
        burst(0, 5, 100, 5);
        // Non-power-of-two D queue with random back-pressure.
        burst(3, 10, 50, 0);
        burst(2, 6, 60, 0);

        // Zero-latency bypass on the flow A queue.
        idle();
        repeat (4) tick();
        nb = rnd_beat(2);
        nb[323:288] = 36'h8_0000_0040;
        ib[2] = nb;
        iv[2] = 1'b1;
        #1;
        check("bypass out_valid", PW'(ov[2]), PW'(1));
        check("bypass address", PW'(ob[2][323:288]), PW'(36'h8_0000_0040));
        check("bypass count before", PW'(cnt[2]), PW'(0));
        tick();
        check("bypass count after", PW'(cnt[2]), PW'(0));

        // Full queues with both sides active: pipe keeps count at depth, no-pipe stalls input.
        for (int k = 0; k < 6; k++) begin
            iv[k] = 1'b1; ordy[k] = 1'b0; ib[k] = rnd_beat(k);
        end
        repeat (3) tick();
        for (int k = 0; k < 6; k++) ordy[k] = 1'b1;
        #1;
        check("full pipe in_ready", PW'(ir[0]), PW'(1));
        check("full no-pipe in_ready", PW'(ir[2]), PW'(0));
        n_in = 0; n_out = 0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 6; k++) ib[k] = rnd_beat(k);
            tick();
            n_in  += int'(fired_in[0]);
            n_out += int'(fired_out[0]);
            check("full pipe count", PW'(cnt[0]), PW'(2));
        end
        check("full pipe beats in", PW'(n_in), PW'(8));
        check("full pipe beats out", PW'(n_out), PW'(8));

        // Reset in the middle of traffic.
        idle();
        repeat (4) tick();
        for (int k = 0; k < 6; k++) ordy[k] = 1'b0;
        iv[0] = 1'b1; iv[1] = 1'b1;
        ib[0] = rnd_beat(0); ib[1] = rnd_beat(1);
        tick();
        iv[1] = 1'b0;
        ib[0] = rnd_beat(0);
        tick();
        iv[0] = 1'b0;
        check("pre-reset a_count", PW'(cnt[0]), PW'(2));
        check("pre-reset d_count", PW'(cnt[1]), PW'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-reset a_count", PW'(cnt[0]), PW'(0));
        check("post-reset d_count", PW'(cnt[1]), PW'(0));
        check("post-reset a out_valid", PW'(ov[0]), PW'(0));
        check("post-reset d out_valid", PW'(ov[1]), PW'(0));
        check("post-reset a in_ready", PW'(ir[0]), PW'(1));
        check("post-reset d in_ready", PW'(ir[1]), PW'(1));
        nb = rnd_beat(0);
        ib[0] = nb;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        #1;
        check("post-reset first beat", ob[0], nb);
        tick();

        // Depth-0 channel is pure wiring.
        idle();
        nb = rnd_beat(4);
        ib[4] = nb; iv[4] = 1'b1; ordy[4] = 1'b0;
        #1;
        check("wire out_valid", PW'(ov[4]), PW'(1));
        check("wire in_ready", PW'(ir[4]), PW'(0));
        check("wire bits", ob[4], nb);
        check("wire count", PW'(cnt[4]), PW'(0));
        tick();

        // Random traffic on every channel with occasional reset.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 6; k++) begin
                iv[k]   = ($urandom_range(99) < 70);
                ordy[k] = ($urandom_range(99) < 50);
                ib[k]   = rnd_beat(k);
            end
            reset = ($urandom_range(199) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
